// File: rtl/bp_channel_mux_pkg.sv
// Shared types and helpers for the bytepipe channel multiplexer.
package bp_channel_mux_pkg;

  localparam logic [7:0] DEFAULT_ESC_BYTE = 8'hFE;

  typedef enum logic {
    RX_DATA,
    RX_ESC
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEL,
    TX_DATA
  } tx_state_t;

  // True when the byte following an escape names a real channel.
  function automatic logic isSel(input logic [7:0] b, input int n);
    return (int'(b) < n);
  endfunction

endpackage

// File: rtl/bp_rr_arbiter.sv
// Round-robin pick: first requester strictly after ptr, wrapping; one-hot and index outputs.
module bp_rr_arbiter #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    // Offset N lands back on ptr itself, so the current holder is checked last.
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_channel_mux.sv
// Multiplexes N bytepipe channels over one host byte stream using in-band escape/select codes.
module bp_channel_mux
  import bp_channel_mux_pkg::*;
#(
  parameter int         N_CHANNEL = 2,
  parameter logic [7:0] ESC_BYTE  = DEFAULT_ESC_BYTE,
  parameter int         MAX_BURST = 16,
  localparam int        CHW       = $clog2(N_CHANNEL)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic [7:0]             i_host_data,
  input  logic                   i_host_valid,
  output logic                   o_host_ready,
  output logic [7:0]             o_host_data,
  output logic                   o_host_valid,
  input  logic                   i_host_ready,
  output logic [8*N_CHANNEL-1:0] o_ch_data,
  output logic [N_CHANNEL-1:0]   o_ch_valid,
  input  logic [N_CHANNEL-1:0]   i_ch_ready,
  input  logic [8*N_CHANNEL-1:0] i_ch_data,
  input  logic [N_CHANNEL-1:0]   i_ch_valid,
  output logic [N_CHANNEL-1:0]   o_ch_ready,
  output logic [CHW-1:0]         o_rxSel,
  output logic                   o_rxBadEsc
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  logic active;
  assign active = i_cg && !i_rst;

  // ---------------- RX: host -> channels ----------------
  rx_state_t      rx_state_reg, rx_state_next;
  logic [CHW-1:0] rx_sel_reg, rx_sel_next;
  logic           is_esc, rx_route, host_xfer;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_sel_next   = rx_sel_reg;
    o_host_ready  = 1'b0;
    o_ch_valid    = '0;
    o_rxBadEsc    = 1'b0;
    is_esc        = (i_host_data == ESC_BYTE);
    // A plain byte in RX_DATA, or a doubled ESC, is payload for the selected channel.
    rx_route      = (rx_state_reg == RX_DATA) ? !is_esc : is_esc;
    if (active) begin
      if (rx_route) begin
        o_ch_valid[rx_sel_reg] = i_host_valid;
        o_host_ready           = i_ch_ready[rx_sel_reg];
      end else begin
        o_host_ready = 1'b1;
      end
    end
    host_xfer = i_host_valid && o_host_ready;
    if (host_xfer) begin
      if (rx_state_reg == RX_DATA) begin
        if (is_esc) rx_state_next = RX_ESC;
      end else begin
        rx_state_next = RX_DATA;
        if (!is_esc) begin
          if (isSel(i_host_data, N_CHANNEL)) rx_sel_next = CHW'(i_host_data);
          else                               o_rxBadEsc  = 1'b1;
        end
      end
    end
  end

  assign o_rxSel = rx_sel_reg;

  logic [7:0] tx_lane [N_CHANNEL];

  generate
    for (genvar gi = 0; gi < N_CHANNEL; gi++) begin : g_lane
      assign o_ch_data[gi*8 +: 8] = i_host_data;
      assign tx_lane[gi]          = i_ch_data[gi*8 +: 8];
    end
  endgenerate

  // ---------------- TX: channels -> host ----------------
  tx_state_t            tx_state_reg, tx_state_next;
  logic [CHW-1:0]       grant_reg, grant_next;
  logic [N_CHANNEL-1:0] grant_oh_reg, grant_oh_next;
  logic [CHW:0]         last_sel_reg, last_sel_next;
  logic [BW-1:0]        burst_reg, burst_next;
  logic                 esc_pend_reg, esc_pend_next;
  logic                 out_valid_reg, out_valid_next;
  logic [7:0]           out_data_reg, out_data_next;
  logic                 advance, load;
  logic [7:0]           load_byte, grant_data;
  logic                 grant_valid;
  logic [N_CHANNEL-1:0] arb_gnt;
  logic [CHW-1:0]       arb_idx;
  logic                 arb_any;

  bp_rr_arbiter #(.N(N_CHANNEL)) u_arb (
    .req     (i_ch_valid),
    .ptr     (grant_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign grant_data  = tx_lane[grant_reg];
  assign grant_valid = i_ch_valid[grant_reg];
  assign advance     = active && (!out_valid_reg || i_host_ready);

  always_comb begin
    tx_state_next = tx_state_reg;
    grant_next    = grant_reg;
    grant_oh_next = grant_oh_reg;
    last_sel_next = last_sel_reg;
    burst_next    = burst_reg;
    esc_pend_next = esc_pend_reg;
    load          = 1'b0;
    load_byte     = out_data_reg;
    o_ch_ready    = '0;
    if (advance) begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (arb_any) begin
            grant_next    = arb_idx;
            grant_oh_next = arb_gnt;
            burst_next    = '0;
            if ({1'b0, arb_idx} != last_sel_reg) begin
              load          = 1'b1;
              load_byte     = ESC_BYTE;
              tx_state_next = TX_SEL;
            end else begin
              tx_state_next = TX_DATA;
            end
          end
        end
        TX_SEL: begin
          load          = 1'b1;
          load_byte     = 8'(grant_reg);
          last_sel_next = {1'b0, grant_reg};
          tx_state_next = TX_DATA;
        end
        TX_DATA: begin
          if (grant_valid) begin
            // An ESC payload byte goes out twice; the channel is only acked on the second copy.
            if (grant_data == ESC_BYTE && !esc_pend_reg) begin
              load          = 1'b1;
              load_byte     = ESC_BYTE;
              esc_pend_next = 1'b1;
            end else begin
              load          = 1'b1;
              load_byte     = grant_data;
              o_ch_ready    = grant_oh_reg;
              esc_pend_next = 1'b0;
              burst_next    = burst_reg + 1'b1;
              if (burst_reg == BW'(MAX_BURST - 1)) tx_state_next = TX_IDLE;
            end
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
        default: tx_state_next = TX_IDLE;
      endcase
    end
    out_valid_next = advance ? load : out_valid_reg;
    out_data_next  = (advance && load) ? load_byte : out_data_reg;
  end

  assign o_host_valid = out_valid_reg && i_cg;
  assign o_host_data  = out_data_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state_reg  <= RX_DATA;
      rx_sel_reg    <= '0;
      tx_state_reg  <= TX_IDLE;
      grant_reg     <= CHW'(N_CHANNEL - 1);
      grant_oh_reg  <= {1'b1, {(N_CHANNEL-1){1'b0}}};
      last_sel_reg  <= (CHW+1)'(N_CHANNEL);
      burst_reg     <= '0;
      esc_pend_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'h00;
    end else if (i_cg) begin
      rx_state_reg  <= rx_state_next;
      rx_sel_reg    <= rx_sel_next;
      tx_state_reg  <= tx_state_next;
      grant_reg     <= grant_next;
      grant_oh_reg  <= grant_oh_next;
      last_sel_reg  <= last_sel_next;
      burst_reg     <= burst_next;
      esc_pend_reg  <= esc_pend_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

endmodule

// File: tb/tb_bp_channel_mux.sv
// Randomised bench for bp_channel_mux: stream-level framing model for both directions.
module tb_bp_channel_mux;

  localparam int         N_CH = 2;
  localparam int         MB   = 4;
  localparam logic [7:0] ESC  = 8'hFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cg;
  logic [7:0]        h_din;
  logic              h_vin;
  logic              h_rdy;
  logic [7:0]        h_dout;
  logic              h_vout;
  logic              h_rin;
  logic [8*N_CH-1:0] ch_dout;
  logic [N_CH-1:0]   ch_vout;
  logic [N_CH-1:0]   ch_rin;
  logic [8*N_CH-1:0] ch_din;
  logic [N_CH-1:0]   ch_vin;
  logic [N_CH-1:0]   ch_rout;
  logic [0:0]        rx_sel;
  logic              rx_bad;

  bp_channel_mux #(.N_CHANNEL(N_CH), .ESC_BYTE(ESC), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg),
    .i_host_data(h_din), .i_host_valid(h_vin), .o_host_ready(h_rdy),
    .o_host_data(h_dout), .o_host_valid(h_vout), .i_host_ready(h_rin),
    .o_ch_data(ch_dout), .o_ch_valid(ch_vout), .i_ch_ready(ch_rin),
    .i_ch_data(ch_din), .i_ch_valid(ch_vin), .o_ch_ready(ch_rout),
    .o_rxSel(rx_sel), .o_rxBadEsc(rx_bad)
  );

  int checks = 0;
  int errors = 0;

  // Model state that survives between scenarios (cleared by reset).
  int m_rx_sel, m_rx_esc, m_grant, m_last;

  logic [7:0] hq[$];
  logic [7:0] exp_rx [N_CH][$];
  logic [7:0] got_rx [N_CH][$];
  logic [7:0] txq    [N_CH][$];
  logic [7:0] mq     [N_CH][$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cg = 1'b1; h_vin = 1'b0; ch_vin = '0; h_rin = 1'b0; ch_rin = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_rx_sel = 0; m_rx_esc = 0; m_grant = N_CH - 1; m_last = N_CH;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; cg = 1'b1; h_vin = 1'b1; h_din = 8'h41; ch_rin = '1; ch_vin = '1;
    ch_din = {N_CH{8'h12}}; h_rin = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (h_vout !== 1'b0) begin errors++; $display("FAIL reset_host_valid got=%b exp=0", h_vout); end
    checks++; if (h_dout !== 8'h00) begin errors++; $display("FAIL reset_host_data got=%h exp=00", h_dout); end
    checks++; if (h_rdy !== 1'b0) begin errors++; $display("FAIL reset_host_ready got=%b exp=0", h_rdy); end
    checks++; if (ch_vout !== '0) begin errors++; $display("FAIL reset_ch_valid got=%b exp=0", ch_vout); end
    checks++; if (ch_rout !== '0) begin errors++; $display("FAIL reset_ch_ready got=%b exp=0", ch_rout); end
    checks++; if (rx_sel !== 1'b0) begin errors++; $display("FAIL reset_rxsel got=%0d exp=0", rx_sel); end
    checks++; if (rx_bad !== 1'b0) begin errors++; $display("FAIL reset_badesc got=%b exp=0", rx_bad); end
    $display("reset: outputs checked while reset held");
    do_reset();
  endtask

  // Sends hq to the DUT; mode 0 = always valid/ready, mode 1 = random gaps.
  task automatic run_rx(input string name, input int mode);
    int exp_bad, got_bad, cyc;
    exp_bad = 0; got_bad = 0; cyc = 0;
    for (int c = 0; c < N_CH; c++) begin exp_rx[c].delete(); got_rx[c].delete(); end
    foreach (hq[i]) begin
      if (m_rx_esc == 0) begin
        if (hq[i] == ESC) m_rx_esc = 1;
        else exp_rx[m_rx_sel].push_back(hq[i]);
      end else begin
        m_rx_esc = 0;
        if (hq[i] == ESC)           exp_rx[m_rx_sel].push_back(hq[i]);
        else if (int'(hq[i]) < N_CH) m_rx_sel = int'(hq[i]);
        else                         exp_bad++;
      end
    end
    while (hq.size() > 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      h_vin = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      h_din = h_vin ? hq[0] : 8'($urandom);
      for (int c = 0; c < N_CH; c++) ch_rin[c] = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ((ch_vout & (ch_vout - 1'b1)) != '0) begin
        errors++; $display("FAIL %s rx_valid_onehot got=%b", name, ch_vout);
      end
      if (h_vin && h_rdy) void'(hq.pop_front());
      for (int c = 0; c < N_CH; c++)
        if (ch_vout[c] && ch_rin[c]) got_rx[c].push_back(ch_dout[c*8 +: 8]);
      if (rx_bad) got_bad++;
    end
    @(negedge clk);
    h_vin = 1'b0;
    #1;
    checks++; if (cyc >= 1000) begin errors++; $display("FAIL %s rx_timeout left=%0d exp=0", name, hq.size()); end
    for (int c = 0; c < N_CH; c++) begin
      checks++;
      if (got_rx[c].size() != exp_rx[c].size()) begin
        errors++; $display("FAIL %s rx_count ch%0d got=%0d exp=%0d", name, c, got_rx[c].size(), exp_rx[c].size());
      end else begin
        foreach (exp_rx[c][i]) begin
          checks++;
          if (got_rx[c][i] !== exp_rx[c][i]) begin
            errors++; $display("FAIL %s rx_byte ch%0d[%0d] got=%h exp=%h", name, c, i, got_rx[c][i], exp_rx[c][i]);
          end
        end
      end
    end
    checks++; if (got_bad != exp_bad) begin errors++; $display("FAIL %s bad_esc got=%0d exp=%0d", name, got_bad, exp_bad); end
    checks++; if (int'(rx_sel) != m_rx_sel) begin errors++; $display("FAIL %s rxsel got=%0d exp=%0d", name, rx_sel, m_rx_sel); end
    $display("%s: ch0=%0d ch1=%0d bytes, bad_esc=%0d, rxSel=%0d", name, got_rx[0].size(), got_rx[1].size(), got_bad, rx_sel);
  endtask

  // Streams txq out; mode 0 = host always ready, 1 = random host stalls, 2 = one long stall + clock-gate window.
  task automatic run_tx(input string name, input int mode);
    int cyc, hold, hold_done, g;
    logic [7:0] held, b;
    cyc = 0; hold = 0; hold_done = 0; held = 8'h00;
    exp_tx.delete(); got_tx.delete();
    for (int c = 0; c < N_CH; c++) mq[c] = txq[c];
    // Round-robin over non-empty channels, MB bytes per grant, select prefix on channel change, ESC doubled.
    while (1) begin
      g = -1;
      for (int k = 1; k <= N_CH; k++)
        if (g < 0 && mq[(m_grant + k) % N_CH].size() > 0) g = (m_grant + k) % N_CH;
      if (g < 0) break;
      m_grant = g;
      if (g != m_last) begin exp_tx.push_back(ESC); exp_tx.push_back(8'(g)); m_last = g; end
      for (int n = 0; n < MB && mq[g].size() > 0; n++) begin
        b = mq[g].pop_front();
        if (b == ESC) exp_tx.push_back(ESC);
        exp_tx.push_back(b);
      end
    end
    while (got_tx.size() < exp_tx.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mode == 2 && hold_done == 0 && got_tx.size() >= 3 && h_vout) begin
        hold = 15; hold_done = 1; held = h_dout;
      end
      cg = 1'b1;
      h_rin = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (hold > 0) begin
        if (hold > 5) h_rin = 1'b0;
        else          cg = 1'b0;
      end
      for (int c = 0; c < N_CH; c++) begin
        ch_vin[c] = (txq[c].size() > 0);
        ch_din[c*8 +: 8] = ch_vin[c] ? txq[c][0] : 8'h00;
      end
      #1;
      if (hold > 0) begin
        checks++;
        if (h_dout !== held) begin errors++; $display("FAIL %s hold_data got=%h exp=%h", name, h_dout, held); end
        if (hold <= 5) begin
          checks++;
          if (h_vout !== 1'b0 || ch_rout !== '0 || h_rdy !== 1'b0) begin
            errors++; $display("FAIL %s cg_gate valid=%b ch_ready=%b host_ready=%b exp=0", name, h_vout, ch_rout, h_rdy);
          end
        end
        hold--;
      end
      if (h_vout && h_rin) got_tx.push_back(h_dout);
      for (int c = 0; c < N_CH; c++)
        if (ch_vin[c] && ch_rout[c]) void'(txq[c].pop_front());
    end
    checks++; if (cyc >= 3000) begin errors++; $display("FAIL %s tx_timeout got=%0d exp=%0d", name, got_tx.size(), exp_tx.size()); end
    cg = 1'b1;
    repeat (4) begin
      @(negedge clk);
      h_rin = 1'b1;
      for (int c = 0; c < N_CH; c++) ch_vin[c] = (txq[c].size() > 0);
      #1;
      if (h_vout) got_tx.push_back(h_dout);
      for (int c = 0; c < N_CH; c++)
        if (ch_vin[c] && ch_rout[c]) void'(txq[c].pop_front());
    end
    ch_vin = '0;
    checks++;
    if (got_tx.size() != exp_tx.size()) begin
      errors++; $display("FAIL %s tx_count got=%0d exp=%0d", name, got_tx.size(), exp_tx.size());
    end else begin
      foreach (exp_tx[i]) begin
        checks++;
        if (got_tx[i] !== exp_tx[i]) begin
          errors++; $display("FAIL %s tx_byte[%0d] got=%h exp=%h", name, i, got_tx[i], exp_tx[i]);
        end
      end
    end
    $display("%s: host received %0d bytes, expected %0d", name, got_tx.size(), exp_tx.size());
  endtask

  task automatic test_rx_basic();
    hq = '{8'h41, 8'h42};
    run_rx("rx_basic", 0);
  endtask

  task automatic test_rx_select();
    hq = '{8'hFE, 8'h01, 8'h33, 8'hFE, 8'hFE};
    run_rx("rx_select", 0);
  endtask

  task automatic test_rx_bad_esc();
    do_reset();
    hq = '{8'hFE, 8'h07, 8'h10};
    run_rx("rx_bad_esc", 0);
  endtask

  task automatic test_rx_random();
    for (int r = 0; r < 2; r++) begin
      hq.delete();
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(0, 5))
          0, 1:    hq.push_back(ESC);
          2:       hq.push_back(8'h00);
          3:       hq.push_back(8'h01);
          4:       hq.push_back(8'h07);
          default: hq.push_back(8'($urandom));
        endcase
      end
      run_rx("rx_random", 1);
    end
  endtask

  task automatic test_tx_select();
    do_reset();
    txq[1] = '{8'h55};
    run_tx("tx_select", 0);
  endtask

  task automatic test_tx_escape();
    txq[1] = '{8'hFE};
    run_tx("tx_escape", 0);
  endtask

  task automatic test_tx_burst();
    for (int c = 0; c < N_CH; c++) begin
      txq[c].delete();
      for (int i = 0; i < 12; i++) txq[c].push_back(8'(16 * c + i));
    end
    run_tx("tx_burst", 0);
  endtask

  task automatic test_tx_hold();
    txq[0].delete();
    for (int i = 0; i < 8; i++) txq[0].push_back(8'(8'hA0 + i));
    run_tx("tx_hold", 2);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        txq[c].delete();
        for (int i = 0; i < int'($urandom_range(0, 10)); i++)
          txq[c].push_back(($urandom_range(0, 3) == 0) ? ESC : 8'($urandom));
      end
      run_tx("tx_random", 1);
    end
  endtask

  initial begin
    rst = 1'b1; cg = 1'b1; h_din = 8'h00; h_vin = 1'b0; h_rin = 1'b0;
    ch_rin = '0; ch_din = '0; ch_vin = '0;
    test_reset();
    test_rx_basic();
    test_rx_select();
    test_rx_bad_esc();
    test_rx_random();
    test_tx_select();
    test_tx_escape();
    test_tx_burst();
    test_tx_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_channel_mux.md
# bp_channel_mux

Multiplexes N_CHANNEL independent bytepipe (BP) targets, e.g. several correlator/debug engines, over the single byte stream provided by the USB full-speed serial device. It sits between the USB serial block and the per-channel register/engine blocks. In-band escape sequences carry channel selection in both directions; the transmit path arbitrates round-robin with a burst limit.

## Interface
- N_CHANNEL, 2: number of BP channels, 2..16.
- ESC_BYTE, 8'hFE: escape byte; must be ≥ N_CHANNEL.
- MAX_BURST, 16: maximum data bytes per transmit grant, 1..256.
- CHW, $clog2(N_CHANNEL): channel index width (derived, not overridable).

- i_clk  in  1  single clock (48MHz domain).
- i_rst  in  1  synchronous, active-high reset.
- i_cg  in  1  clock-gate enable; low freezes all state.
- i_host_data  in  8  host-to-device byte from the USB serial block.
- i_host_valid  in  1  valid for i_host_data.
- o_host_ready  out  1  ready for i_host_data.
- o_host_data  out  8  device-to-host byte, registered.
- o_host_valid  out  1  valid for o_host_data, registered.
- i_host_ready  in  1  ready for o_host_data.
- o_ch_data  out  8*N_CHANNEL  per-channel RX byte; all lanes carry the same byte.
- o_ch_valid  out  N_CHANNEL  per-channel RX valid (one-hot or zero).
- i_ch_ready  in  N_CHANNEL  per-channel RX ready.
- i_ch_data  in  8*N_CHANNEL  per-channel TX byte.
- i_ch_valid  in  N_CHANNEL  per-channel TX valid.
- o_ch_ready  out  N_CHANNEL  per-channel TX ready (one-hot or zero).
- o_rxSel  out  CHW  current RX channel.
- o_rxBadEsc  out  1  one-cycle pulse on an invalid escape code.

## Operation
- Handshake everywhere: a transfer occurs on a cycle with valid && ready && i_cg. A valid byte is held stable until it is transferred.
- i_cg low: all registers hold; o_host_ready, o_host_valid, o_ch_valid and o_ch_ready are forced to 0.
- RX FSM, states RX_DATA and RX_ESC; reset to RX_DATA with rxSel=0:
  - RX_DATA, byte≠ESC: route to channel rxSel. o_ch_valid[rxSel]=i_host_valid and o_host_ready=i_ch_ready[rxSel].
  - RX_DATA, byte==ESC: consume it (ready=1) and go to RX_ESC.
  - RX_ESC, byte==ESC: route literal ESC to rxSel as above; on transfer go to RX_DATA.
  - RX_ESC, byte<N_CHANNEL: consume it, set rxSel←byte, go to RX_DATA.
  - RX_ESC, any other byte: consume and discard it, pulse o_rxBadEsc, go to RX_DATA; rxSel is unchanged.
- TX path: an output register (oValid, oData) loads when canLoad = !oValid || i_host_ready. The FSM advances only on canLoad.
- TX FSM, states TX_IDLE, TX_SEL, TX_DATA; reset to TX_IDLE with lastSel=N_CHANNEL (invalid), grant=N_CHANNEL-1, burst=0, escPend=0:
  - TX_IDLE: if any i_ch_valid, grant←first valid channel searching from grant+1 (wrapping), burst←0.
    - If the new grant≠lastSel: load ESC and go to TX_SEL.
    - Otherwise go to TX_DATA without loading (one-cycle bubble).
  - TX_SEL: load grant, lastSel←grant, go to TX_DATA.
  - TX_DATA with i_ch_valid[grant]:
    - Data==ESC and !escPend: load ESC, escPend←1, do not consume.
    - Otherwise: load data, o_ch_ready[grant]=1, escPend←0, burst++. If burst==MAX_BURST-1, go to TX_IDLE.
  - TX_DATA with !i_ch_valid[grant]: go to TX_IDLE.
  - The escape pair is never split by re-arbitration, and an escaped byte counts once toward the burst.
- Reset values: o_host_valid=0, o_host_data=0, o_host_ready=0, o_ch_valid=0, o_ch_ready=0, o_rxSel=0, o_rxBadEsc=0. Reset mid-packet discards any partial escape or burst.

## Timing
- RX: zero latency. Valid/ready pass combinationally through the selected channel; select/escape bytes take one cycle each.
- TX: data appears on o_host_data the cycle after its channel handshake. The throughput limit is 1 byte/cycle inside a burst.
- Grant overhead: 1 cycle in TX_IDLE, plus 2 output bytes when the channel changes.
- Simultaneous RX and TX operation is independent.
- A channel that is valid is guaranteed a grant within (N_CHANNEL-1) bursts.

## Structure
- Package bp_channel_mux_pkg holds:
  - RX and TX state enums.
  - Default ESC_BYTE localparam.
  - Function isSel(byte, n) for select-byte decode.
- Sub-module bp_rr_arbiter (parametrised N, one-hot grant from a pointer) instantiated in the TX path. Everything else is inline.

## Test plan
- Reset, then host sends 0x41 0x42 with all channels ready → channel 0 receives 0x41 then 0x42; o_rxSel=0.
- Host sends FE 01 33 FE FE → channel 1 receives 0x33 and 0xFE; o_rxSel=1; no o_rxBadEsc.
- Host sends FE 07 with N_CHANNEL=2 → o_rxBadEsc pulses once; rxSel stays 0; next byte 0x10 goes to channel 0.
- Channel 1 sends 0x55 from reset → host receives FE 01 55.
- Channel 1 then sends 0xFE → host receives FE FE with no re-select.
- MAX_BURST=4, channels 0 and 1 both stream continuously → host sees FE 00 + 4 bytes, FE 01 + 4 bytes, alternating.
- Host holds i_host_ready=0 for 10 cycles mid-burst, and i_cg is low for 5 cycles → no byte lost or duplicated; o_host_data stable throughout.
